// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational ALU.
// Each operation takes three cycles: IDLE (grant and latch), EXEC (ALU enabled),
// DONE (result pulse).
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [2:0]       op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             done0,
  output logic [WIDTH-1:0] res0,
  input  logic             req1,
  input  logic [2:0]       op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             done1,
  output logic [WIDTH-1:0] res1,
  output logic             alu_e,
  output logic [2:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_q,  last_d;
  logic [2:0]       op_q,    op_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] res0_q,  res0_d;
  logic [WIDTH-1:0] res1_q,  res1_d;
  logic             pick;

  // Round-robin pick: on a tie the requester not served last wins.
  always_comb begin
    pick = 1'b0;
    if (req0 && req1) begin
      pick = ~last_q;
    end else if (req1) begin
      pick = 1'b1;
    end
  end

  // Next-state, operand latching and result capture.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res0_d  = res0_q;
    res1_d  = res1_q;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_d = pick;
          op_d    = pick ? op1 : op0;
          a_d     = pick ? a1  : a0;
          b_d     = pick ? b1  : b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (grant_q) begin
          res1_d = alu_y;
        end else begin
          res0_d = alu_y;
        end
        last_d  = grant_q;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset; last pointer resets to 1 so
  // requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res0_q  <= '0;
      res1_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res0_q  <= res0_d;
      res1_q  <= res1_d;
    end
  end

  // Outputs decoded from state and registers.
  always_comb begin
    alu_e      = (state_q == EXEC);
    busy       = (state_q != IDLE);
    done0      = (state_q == DONE) && !grant_q;
    done1      = (state_q == DONE) &&  grant_q;
    alu_opcode = op_q;
    alu_a      = a_q;
    alu_b      = b_q;
    res0       = res0_q;
    res1       = res1_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a behavioural ALU on alu_y.
module tb_alu_arbiter;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1;
  logic [2:0]       op0, op1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic             done0, done1;
  logic [WIDTH-1:0] res0, res1;
  logic             alu_e;
  logic [2:0]       alu_opcode;
  logic [WIDTH-1:0] alu_a, alu_b, alu_y;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0), .done0(done0), .res0(res0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1), .done1(done1), .res1(res1),
    .alu_e(alu_e), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural shared ALU.
  always_comb begin
    alu_y = '0;
    case (alu_opcode)
      3'd0: alu_y = alu_a + alu_b;
      3'd1: alu_y = alu_a - alu_b;
      3'd2: alu_y = ~alu_a;
      3'd3: alu_y = alu_a + 1'b1;
      3'd4: alu_y = alu_a - 1'b1;
      3'd5: alu_y = alu_a;
      3'd6: alu_y = alu_a | alu_b;
      3'd7: alu_y = alu_a & alu_b;
      default: alu_y = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [3:0] grants;
  int         n_ops;

  initial begin
    rst = 1'b1; req0 = 0; req1 = 0;
    op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    do_reset();

    // Reset state
    check("rst_busy",   busy, 0);
    check("rst_alu_e",  alu_e, 0);
    check("rst_done",   {done1, done0}, 0);
    check("rst_res0",   res0, 0);
    check("rst_res1",   res1, 0);
    check("rst_opcode", alu_opcode, 0);
    check("rst_alu_a",  alu_a, 0);
    check("rst_alu_b",  alu_b, 0);

    // Single add 5+3
    req0 = 1; op0 = 3'd0; a0 = 5; b0 = 3;
    step();
    check("add_exec_e", alu_e, 1);
    check("add_exec_a", alu_a, 5);
    check("add_exec_b", alu_b, 3);
    check("add_busy",   busy, 1);
    check("add_exec_done", done0, 0);
    step();
    check("add_done0", done0, 1);
    check("add_done1", done1, 0);
    check("add_res0",  res0, 8);
    check("add_done_e", alu_e, 0);
    req0 = 0;
    step();
    check("add_idle_busy", busy, 0);
    check("add_idle_done", done0, 0);
    check("add_hold_a", alu_a, 5);

    // Tie after reset: requester 0 first, then requester 1
    do_reset();
    req0 = 1; op0 = 3'd1; a0 = 10; b0 = 4;
    req1 = 1; op1 = 3'd7; a1 = 32'hF0F0; b1 = 32'hFF00;
    step();
    check("tie_op_first", alu_opcode, 1);
    step();
    check("tie_done0", done0, 1);
    check("tie_res0",  res0, 6);
    check("tie_res1_hold", res1, 0);
    req0 = 0;
    step();
    check("tie_idle_busy", busy, 0);
    step();
    check("tie_op_second", alu_opcode, 7);
    check("tie_e_second",  alu_e, 1);
    step();
    check("tie_done1", done1, 1);
    check("tie_done0_lo", done0, 0);
    check("tie_res1", res1, 32'hF000);
    check("tie_res0_hold", res0, 6);
    req1 = 0;
    step();

    // Wrap-around increment then decrement, req held through DONE
    req1 = 1; op1 = 3'd3; a1 = 32'hFFFF_FFFF;
    step();
    step();
    check("inc_done1", done1, 1);
    check("inc_res1",  res1, 0);
    op1 = 3'd4; a1 = 0;
    step();
    check("dec_idle_busy", busy, 0);
    step();
    check("dec_exec_e", alu_e, 1);
    step();
    check("dec_done1", done1, 1);
    check("dec_res1",  res1, 32'hFFFF_FFFF);
    req1 = 0;
    step();

    // Reset during EXEC aborts the operation
    req0 = 1; op0 = 3'd0; a0 = 1; b0 = 1;
    step();
    check("abort_exec_e", alu_e, 1);
    rst = 1; req0 = 0;
    step();
    check("abort_done0", done0, 0);
    check("abort_res0",  res0, 0);
    check("abort_alu_e", alu_e, 0);
    check("abort_busy",  busy, 0);
    rst = 0;
    step();
    check("abort_idle_done", done0, 0);
    req0 = 1; op0 = 3'd0; a0 = 2; b0 = 3;
    step();
    step();
    check("after_abort_done0", done0, 1);
    check("after_abort_res0",  res0, 5);
    req0 = 0;
    step();

    // Request dropped during EXEC still completes
    req0 = 1; op0 = 3'd2; a0 = 0;
    step();
    req0 = 0;
    step();
    check("drop_done0", done0, 1);
    check("drop_res0",  res0, 32'hFFFF_FFFF);
    step();

    // Continuous contention for 12 cycles alternates grants
    do_reset();
    req0 = 1; op0 = 3'd5; a0 = 32'h11;
    req1 = 1; op1 = 3'd5; a1 = 32'h22;
    grants = '0;
    n_ops = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done0 || done1) begin
        if (n_ops < 4) grants[n_ops] = done1;
        n_ops++;
      end
    end
    req0 = 0; req1 = 0;
    check("rr_ops", n_ops, 4);
    check("rr_order", grants, 4'b1010);
    check("rr_res0", res0, 32'h11);
    check("rr_res1", res1, 32'h22);
    step();
    check("rr_end_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
